// File: rtl/mem_sequencer.sv
// mem_sequencer
// Sequences a four-table character substitution core one character at a time.
// Letters 'A'..'Z' go through the core. Every other character bypasses it.
// The table setting advances after every STEP_PERIOD letters, which gives
// rotor-style stepping.
//
// Parameters
//   SUB_LATENCY  cycles from driving sub_in/sub_setting to sampling sub_out (>=1)
//   STEP_PERIOD  letters encrypted per setting advance (1..255)
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   key_load     load the initial setting (only honoured in IDLE)
//   key          setting value loaded by key_load
//   in_valid     upstream character valid
//   in_ready     upstream ready: (state==IDLE) && !key_load
//   in_char      upstream ASCII character
//   sub_in       registered character driven to the substitution core
//   sub_setting  table select to the core (same as setting)
//   sub_out      substituted character from the core
//   out_valid    downstream character valid (registered)
//   out_ready    downstream accept
//   out_char     registered result character
//   setting      current table setting
//   enc_count    letters encrypted since reset, wraps 0xFFFF -> 0
//   dbg_state    current FSM state (0=IDLE, 1=WAIT, 2=HOLD) for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The source holds its data stable while valid is high and ready
// is low. out_valid does not depend on out_ready.
module mem_sequencer #(
    parameter int SUB_LATENCY = 2,
    parameter int STEP_PERIOD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_load,
    input  logic [1:0] key,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:1] in_char,
    output logic [8:1] sub_in,
    output logic [1:0] sub_setting,
    input  logic [8:1] sub_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:1] out_char,
    output logic [1:0] setting,
    output logic [15:0] enc_count,
    output logic [1:0] dbg_state
);

    localparam int WW = (SUB_LATENCY > 1) ? $clog2(SUB_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] wait_cnt;
    logic [7:0]    letter_cnt;
    logic          held_letter;   // the character in HOLD went through the core

    logic is_letter;
    logic accept;
    logic capture;
    logic release_out;

    assign is_letter = (in_char >= 8'h41) && (in_char <= 8'h5A);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = is_letter ? ST_WAIT : ST_HOLD;
                end
            end
            ST_WAIT: begin
                if (capture) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (release_out) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        in_ready    = (state == ST_IDLE) && !key_load;
        accept      = in_valid && in_ready;
        capture     = (state == ST_WAIT) && (wait_cnt == '0);
        release_out = (state == ST_HOLD) && out_ready;
        dbg_state   = state;
    end

    // The core sees the live setting. It only changes on HOLD->IDLE or on
    // key_load in IDLE, so it stays fixed while a character is in the core.
    assign sub_setting = setting;

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            setting     <= 2'd0;
            letter_cnt  <= 8'd0;
            enc_count   <= 16'd0;
            sub_in      <= 8'd0;
            out_char    <= 8'd0;
            out_valid   <= 1'b0;
            wait_cnt    <= '0;
            held_letter <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_load) begin
                        setting    <= key;
                        letter_cnt <= 8'd0;
                    end else if (in_valid) begin
                        if (is_letter) begin
                            sub_in      <= in_char;
                            wait_cnt    <= WW'(SUB_LATENCY - 1);
                            held_letter <= 1'b1;
                        end else begin
                            out_char    <= in_char;
                            out_valid   <= 1'b1;
                            held_letter <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        out_char  <= sub_out;
                        out_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (held_letter) begin
                            enc_count <= enc_count + 16'd1;
                            if (letter_cnt == 8'(STEP_PERIOD - 1)) begin
                                letter_cnt <= 8'd0;
                                setting    <= setting + 2'd1;
                            end else begin
                                letter_cnt <= letter_cnt + 8'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer. Two instances share the stimulus:
// dut_a with default parameters and dut_b with STEP_PERIOD=3. Each has its
// own model of the four-table core, registered so that sub_out reflects
// sub_in one edge later (SUB_LATENCY=2).
module tb_mem_sequencer;

    localparam int LAT = 2;

    logic       clk;
    logic       rst_n;
    logic       key_load;
    logic [1:0] key;
    logic       in_valid;
    logic [7:0] in_char;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [7:0] sub_in_a, sub_out_a, out_char_a, sub_in_b, sub_out_b, out_char_b;
    logic [1:0] sub_setting_a, setting_a, dbg_state_a, sub_setting_b, setting_b, dbg_state_b;
    logic [15:0] enc_count_a, enc_count_b;

    int vectors = 0;
    int fails   = 0;

    mem_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key(key),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_char(in_char),
        .sub_in(sub_in_a), .sub_setting(sub_setting_a), .sub_out(sub_out_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_char(out_char_a),
        .setting(setting_a), .enc_count(enc_count_a), .dbg_state(dbg_state_a)
    );

    mem_sequencer #(.SUB_LATENCY(2), .STEP_PERIOD(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key(key),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_char(in_char),
        .sub_in(sub_in_b), .sub_setting(sub_setting_b), .sub_out(sub_out_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_char(out_char_b),
        .setting(setting_b), .enc_count(enc_count_b), .dbg_state(dbg_state_b)
    );

    // Four-table core model. Tables 0..2 are shifts by 14, 23 and 17.
    // Table 3 is the affine map 19*x+5. Non-letters pass through.
    function automatic logic [7:0] core_f(input logic [7:0] c, input logic [1:0] s);
        int idx;
        int r;
        if (c < 8'h41 || c > 8'h5A) return c;
        idx = int'(c) - 65;
        case (s)
            2'd0: r = (idx + 14) % 26;
            2'd1: r = (idx + 23) % 26;
            2'd2: r = (idx + 17) % 26;
            default: r = (idx * 19 + 5) % 26;
        endcase
        return 8'(r + 65);
    endfunction

    always_ff @(posedge clk) begin
        sub_out_a <= core_f(sub_in_a, sub_setting_a);
        sub_out_b <= core_f(sub_in_b, sub_setting_b);
    end

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Sends one character on dut_a's handshake, waits for out_valid, checks
    // the latency (cycles counted with the accept cycle as 0) and out_char.
    // Returns with out_valid high, before the release edge.
    task automatic send_char(input logic [7:0] c, input logic [7:0] exp, input string tag);
        int n;
        int exp_lat;
        n = 0;
        while (!in_ready_a && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 32'(in_ready_a), 32'd1);
        in_valid = 1'b1;
        in_char  = c;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_a && n < 20) begin
            tick();
            n++;
        end
        exp_lat = (c >= 8'h41 && c <= 8'h5A) ? LAT + 1 : 1;
        chk({tag, "_lat"}, 32'(n + 1), 32'(exp_lat));
        chk({tag, "_char"}, 32'(out_char_a), 32'(exp));
    endtask

    logic [7:0] exp_def[5];
    logic [1:0] exp_set_def[5];
    logic [7:0] exp_b[7];
    logic [1:0] exp_set_b[7];

    initial begin
        exp_def     = '{8'h4F, 8'h58, 8'h52, 8'h46, 8'h4F};  // "OXRFO"
        exp_set_def = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_b       = '{8'h4F, 8'h4F, 8'h4F, 8'h58, 8'h58, 8'h58, 8'h52};  // "OOOXXXR"
        exp_set_b   = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};

        rst_n     = 1'b0;
        key_load  = 1'b0;
        key       = 2'd0;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        out_ready = 1'b0;

        // Reset values
        do_reset();
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_setting",   32'(setting_a),   32'd0);
        chk("rst_enc",       32'(enc_count_a), 32'd0);
        chk("rst_sub_in",    32'(sub_in_a),    32'd0);
        chk("rst_out_char",  32'(out_char_a),  32'd0);
        chk("rst_in_ready",  32'(in_ready_a),  32'd1);

        // Defaults: "AAAAA" with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_char(8'h41, exp_def[i], $sformatf("def%0d", i));
            tick();
            chk($sformatf("def%0d_set", i), 32'(setting_a), 32'(exp_set_def[i]));
            chk($sformatf("def%0d_ov", i), 32'(out_valid_a), 32'd0);
        end
        chk("def_enc", 32'(enc_count_a), 32'd5);

        // Passthrough of non-letters
        do_reset();
        send_char(8'h41, 8'h4F, "pt_A0");
        tick();
        chk("pt_set0", 32'(setting_a), 32'd1);
        send_char(8'h20, 8'h20, "pt_sp");
        tick();
        chk("pt_set1", 32'(setting_a), 32'd1);
        send_char(8'h61, 8'h61, "pt_a");
        tick();
        chk("pt_set2", 32'(setting_a), 32'd1);
        send_char(8'h41, 8'h58, "pt_A1");
        tick();
        chk("pt_set3", 32'(setting_a), 32'd2);
        chk("pt_enc",  32'(enc_count_a), 32'd2);

        // Key load in IDLE
        do_reset();
        key_load = 1'b1;
        key      = 2'd2;
        in_valid = 1'b1;
        in_char  = 8'h41;
        #1;
        chk("key_in_ready", 32'(in_ready_a), 32'd0);
        tick();
        key_load = 1'b0;
        in_valid = 1'b0;
        chk("key_set", 32'(setting_a), 32'd2);
        chk("key_state", 32'(dbg_state_a), 32'd0);
        send_char(8'h41, 8'h52, "key_A");
        tick();
        chk("key_set1", 32'(setting_a), 32'd3);
        send_char(8'h42, 8'h59, "key_B");
        tick();
        chk("key_set2", 32'(setting_a), 32'd0);

        // Backpressure, then key_load ignored during WAIT
        do_reset();
        out_ready = 1'b0;
        send_char(8'h41, 8'h4F, "bp_A");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp%0d_char", i), 32'(out_char_a),  32'h4F);
            chk($sformatf("bp%0d_ov", i),   32'(out_valid_a), 32'd1);
            chk($sformatf("bp%0d_rdy", i),  32'(in_ready_a),  32'd0);
            chk($sformatf("bp%0d_set", i),  32'(setting_a),   32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_rel_set", 32'(setting_a),   32'd1);
        chk("bp_rel_enc", 32'(enc_count_a), 32'd1);
        chk("bp_rel_ov",  32'(out_valid_a), 32'd0);
        chk("bp_rel_rdy", 32'(in_ready_a),  32'd1);
        in_valid = 1'b1;
        in_char  = 8'h41;
        tick();
        in_valid = 1'b0;
        chk("bp_wait_state", 32'(dbg_state_a), 32'd1);
        key_load = 1'b1;
        key      = 2'd3;
        tick();
        key_load = 1'b0;
        chk("bp_key_ign", 32'(setting_a), 32'd1);
        tick();
        chk("bp2_ov",   32'(out_valid_a), 32'd1);
        chk("bp2_char", 32'(out_char_a),  32'h58);
        tick();
        chk("bp2_set", 32'(setting_a), 32'd2);

        // STEP_PERIOD=3 on dut_b
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send_char(8'h41, core_f(8'h41, setting_a), $sformatf("sp%0d", i));
            chk($sformatf("sp%0d_b_ov", i),   32'(out_valid_b), 32'd1);
            chk($sformatf("sp%0d_b_char", i), 32'(out_char_b),  32'(exp_b[i]));
            tick();
            chk($sformatf("sp%0d_b_set", i), 32'(setting_b), 32'(exp_set_b[i]));
        end
        chk("sp_b_enc", 32'(enc_count_b), 32'd7);

        // Reset during WAIT
        do_reset();
        key_load = 1'b1;
        key      = 2'd2;
        tick();
        key_load = 1'b0;
        chk("mr_set", 32'(setting_a), 32'd2);
        in_valid = 1'b1;
        in_char  = 8'h41;
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_ov",   32'(out_valid_a), 32'd0);
        chk("mr_set0", 32'(setting_a),   32'd0);
        chk("mr_enc",  32'(enc_count_a), 32'd0);
        chk("mr_char", 32'(out_char_a),  32'd0);
        chk("mr_rdy",  32'(in_ready_a),  32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mr_quiet%0d", i), 32'(out_valid_a), 32'd0);
        end
        send_char(8'h41, 8'h4F, "mr_A");
        tick();
        chk("mr_enc1", 32'(enc_count_a), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
